// File: rtl/gate_vector_sequencer_if.sv
// Stimulus/check bus between the gate vector sequencer and its environment.
// master: the sequencer (drives the vector and status, receives start and
//         the gate output).
// slave : the environment (drives start and the gate output).
// Signals:
//   start     - begin a run
//   dut_out   - gate output under test
//   vec_out   - input vector driven to the gate (N_IN bits)
//   busy      - run in progress
//   mismatch  - one-cycle pulse after a failed compare
//   done      - run complete, held until the next start
//   pass      - valid with done, high when no vector failed
//   err_count - failed vectors in the current or last run (N_IN+1 bits)
//   cur_index - index of the vector currently applied (N_IN bits)
interface gate_vector_sequencer_if #(
  parameter int unsigned N_IN = 2
);
  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            mismatch;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] cur_index;

  modport master (
    input  start, dut_out,
    output vec_out, busy, mismatch, done, pass, err_count, cur_index
  );

  modport slave (
    output start, dut_out,
    input  vec_out, busy, mismatch, done, pass, err_count, cur_index
  );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Self-checking stimulus sequencer for an N_IN-input combinational gate.
// Walks every input vector, holds each for HOLD cycles, samples the gate
// output on the last hold edge and compares it with EXP_TABLE[vector].
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - master side of gate_vector_sequencer_if (start/dut_out in,
//           vec_out/busy/mismatch/done/pass/err_count/cur_index out)
// All bus outputs come straight from flops.
module gate_vector_sequencer #(
  parameter int unsigned          N_IN      = 2,
  parameter int unsigned          HOLD      = 10,
  parameter logic [2**N_IN-1:0]   EXP_TABLE = 4'b1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gate_vector_sequencer_if.master bus
);

  localparam int unsigned NVEC = 2**N_IN;
  localparam int unsigned HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned EW   = N_IN + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [EW-1:0]   err_q, err_d;
  logic            mis_q, mis_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic            cmp_edge_c;
  logic            last_vec_c;
  logic            fail_c;

  // Compare happens on the last edge of each vector's hold window.
  assign cmp_edge_c = (state_q == S_DRIVE) && (hold_q == HW'(HOLD - 1));
  assign last_vec_c = (idx_q == N_IN'(NVEC - 1));
  assign fail_c     = cmp_edge_c && (bus.dut_out != EXP_TABLE[idx_q]);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state logic; start is only honoured outside DRIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE,
      S_DONE:  if (bus.start) state_d = S_DRIVE;
      S_DRIVE: if (cmp_edge_c && last_vec_c) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    idx_d  = idx_q;
    hold_d = hold_q;
    err_d  = err_q;
    mis_d  = 1'b0;
    case (state_q)
      S_IDLE,
      S_DONE: begin
        if (bus.start) begin
          idx_d  = '0;
          hold_d = '0;
          err_d  = '0;
        end
      end
      S_DRIVE: begin
        if (cmp_edge_c) begin
          mis_d = fail_c;
          if (fail_c) err_d = err_q + EW'(1);
          // Final vector keeps its index so vec_out holds it in DONE.
          if (!last_vec_c) begin
            idx_d  = idx_q + N_IN'(1);
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: ;
    endcase
    // Status follows the state being entered so pass sees the final count.
    busy_d = (state_d == S_DRIVE);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_d == '0);
  end

  assign bus.vec_out   = idx_q;
  assign bus.cur_index = idx_q;
  assign bus.err_count = err_q;
  assign bus.mismatch  = mis_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;

endmodule
